bwave_stim_source: RTL and testbench

Parametrised, multi-channel replacement for the single free-running DRAM random-data source used in the bwave wrapper benches. It produces `NUM_CH` independent `DWIDTH`-bit stimulus streams, one per channel. Each stream uses a valid/ready handshake and runs in one of four data modes. Each burst has a programmed length and ends with a done pulse. LFSR sequences are reseedable, so runs are reproducible. It sits between the bench/top wrapper and the NPU DRAM or VRF load ports.

---
 rtl/bwave_stim_source.sv | 142 ++++++++++++++
 tb/tb_bwave_stim_source.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwave_stim_source.sv
// Multi-channel burst stimulus source: NUM_CH independent valid/ready streams
// producing LFSR, counter, constant or walking-one words for a programmed length.
module bwave_stim_source #(
  parameter int          DWIDTH = 128,
  parameter int          NUM_CH = 4,
  parameter int          LEN_W  = 10,
  parameter logic [31:0] SEED   = 32'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         burst_len,
  input  logic [1:0]               mode,
  input  logic [DWIDTH-1:0]        cfg_const,
  input  logic                     reseed,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DWIDTH-1:0] out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int LANES = (DWIDTH + 31) / 32;
  localparam int NLFSR = NUM_CH * LANES;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                  state, state_nxt;
  logic [LEN_W-1:0]        rem [NUM_CH];
  logic [LEN_W-1:0]        cnt [NUM_CH];
  logic [31:0]             lfsr [NLFSR];
  logic [1:0]              mode_q;
  logic [DWIDTH-1:0]       const_q;
  logic [NUM_CH-1:0]       acc;
  logic                    load;
  logic                    all_drained;
  logic [LANES*32-1:0]     lane_cat;
  logic [31:0]             cnt32;
  logic [DWIDTH-1:0]       word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Global lane k seeds to SEED+k+1; an all-zero state would lock the LFSR.
  function automatic logic [31:0] lane_seed(input int k);
    logic [31:0] s;
    s = SEED + 32'(k) + 32'd1;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      out_valid[c] = (state == S_RUN) && (rem[c] != '0);
  end

  assign acc = out_valid & out_ready;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    done        = 1'b0;
    load        = 1'b0;
    all_drained = 1'b1;
    // Look at the remaining counts after this cycle's accepts so done lands
    // exactly one cycle after the final accept.
    for (int c = 0; c < NUM_CH; c++)
      if ((rem[c] - LEN_W'(acc[c])) != '0) all_drained = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = (burst_len == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (all_drained) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      for (int c = 0; c < NUM_CH; c++) begin
        rem[c] <= '0;
        cnt[c] <= '0;
      end
      for (int k = 0; k < NLFSR; k++) lfsr[k] <= lane_seed(k);
    end else begin
      state <= state_nxt;
      // Reseed is only honoured in IDLE, where no channel can be stepping.
      if (state == S_IDLE && reseed)
        for (int k = 0; k < NLFSR; k++) lfsr[k] <= lane_seed(k);
      for (int c = 0; c < NUM_CH; c++) begin
        if (load) begin
          rem[c] <= burst_len;
          cnt[c] <= '0;
        end else if (acc[c]) begin
          rem[c] <= rem[c] - 1'b1;
          cnt[c] <= cnt[c] + 1'b1;
          if (mode_q == 2'b00)
            for (int l = 0; l < LANES; l++)
              lfsr[c*LANES+l] <= lfsr_step(lfsr[c*LANES+l]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      mode_q  <= mode;
      const_q <= cfg_const;
    end
  end

  // Output words are formed from registered state only; zero outside RUN.
  always_comb begin
    out_data = '0;
    lane_cat = '0;
    cnt32    = '0;
    word     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int l = 0; l < LANES; l++) lane_cat[l*32 +: 32] = lfsr[c*LANES+l];
      cnt32 = 32'(cnt[c]);
      case (mode_q)
        2'b00:   word = DWIDTH'(lane_cat);
        2'b01:   word = DWIDTH'({LANES{cnt32}});
        2'b10:   word = const_q;
        default: word = DWIDTH'(1) << (cnt32 % 32'(DWIDTH));
      endcase
      if (state == S_RUN) out_data[c*DWIDTH +: DWIDTH] = word;
    end
  end

endmodule

// File: tb/tb_bwave_stim_source.sv
// Self-checking bench for bwave_stim_source: directed scenarios plus randomized
// bursts compared against a transaction-level reference model.
module tb_bwave_stim_source;

  localparam int DW    = 40;
  localparam int NCH   = 2;
  localparam int LW    = 6;
  localparam int LANES = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LW-1:0]     burst_len;
  logic [1:0]        mode;
  logic [DW-1:0]     cfg_const;
  logic              reseed;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*DW-1:0] out_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  bwave_stim_source #(.DWIDTH(DW), .NUM_CH(NCH), .LEN_W(LW), .SEED(32'd0)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .mode(mode),
    .cfg_const(cfg_const), .reseed(reseed), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0]   m_lfsr [NCH*LANES];
  int            m_rem  [NCH];
  logic [LW-1:0] m_cnt  [NCH];
  logic [1:0]    m_mode;
  logic [DW-1:0] m_const;
  bit            m_busy;
  bit            m_done;

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reseed();
    for (int k = 0; k < NCH*LANES; k++) m_lfsr[k] = 32'(k + 1);
  endtask

  task automatic model_reset();
    model_reseed();
    for (int c = 0; c < NCH; c++) begin
      m_rem[c] = 0;
      m_cnt[c] = '0;
    end
    m_busy = 0;
    m_done = 0;
    m_mode = 2'b00;
    m_const = '0;
  endtask

  task automatic model_start(input int len, input logic [1:0] md, input logic [DW-1:0] cst, input bit rs);
    if (rs) model_reseed();
    m_mode  = md;
    m_const = cst;
    for (int c = 0; c < NCH; c++) begin
      m_rem[c] = len;
      m_cnt[c] = '0;
    end
    m_busy = (len != 0);
    m_done = (len == 0);
  endtask

  task automatic model_edge(input logic [NCH-1:0] a);
    bit all_zero;
    if (m_done) m_done = 0;
    else if (m_busy) begin
      all_zero = 1;
      for (int c = 0; c < NCH; c++) begin
        if (a[c]) begin
          m_rem[c]--;
          m_cnt[c] = m_cnt[c] + 1'b1;
          if (m_mode == 2'b00)
            for (int l = 0; l < LANES; l++) m_lfsr[c*LANES+l] = lstep(m_lfsr[c*LANES+l]);
        end
        if (m_rem[c] != 0) all_zero = 0;
      end
      if (all_zero) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  function automatic logic [NCH-1:0] exp_valid();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_busy && (m_rem[c] != 0);
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_data(input int c);
    if (!m_busy) return '0;
    case (m_mode)
      2'b00:   return DW'({m_lfsr[c*LANES+1], m_lfsr[c*LANES]});
      2'b01:   return DW'({2{32'(m_cnt[c])}});
      2'b10:   return m_const;
      default: return DW'(1) << (int'(m_cnt[c]) % DW);
    endcase
  endfunction

  task automatic drive(input logic [NCH-1:0] rdy);
    out_ready = rdy;
    model_edge(exp_valid() & rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len, input logic [1:0] md, input logic [DW-1:0] cst, input bit rs);
    burst_len = LW'(len);
    mode      = md;
    cfg_const = cst;
    reseed    = rs;
    start     = 1'b1;
    out_ready = '0;
    model_start(len, md, cst, rs);
    @(posedge clk);
    #1;
    start  = 1'b0;
    reseed = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_busy || m_done); i++) drive('1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset got busy=%b done=%b valid=%b data=%h, expected all zero", busy, done, out_valid, out_data);
    end
    rst = 1'b1;
    drive('0);
    n_tests++;
    if (busy !== 1'b0 || out_valid !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_idle got busy=%b valid=%b data=%h, expected zeros", busy, out_valid, out_data);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] lv [3];
    lv[0] = 32'h0000_0001;
    lv[1] = 32'h8020_0003;
    lv[2] = 32'hC030_0002;
    do_start(3, 2'b00, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (out_valid !== 2'b11 || busy !== 1'b1 || out_data[31:0] !== lv[i] || out_data[DW +: DW] !== exp_data(1)) begin
        n_fail++;
        $display("FAIL lfsr_word%0d got valid=%b busy=%b ch0=%h ch1=%h, expected 11 1 %h %h",
                 i, out_valid, busy, out_data[31:0], out_data[DW +: DW], lv[i], exp_data(1));
      end
      drive(2'b11);
    end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== '0) begin
      n_fail++;
      $display("FAIL lfsr_done got done=%b busy=%b valid=%b, expected 1 0 00", done, busy, out_valid);
    end
    drive('1);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL lfsr_done_pulse got done=%b, expected 0", done);
    end
  endtask

  task automatic test_reseed();
    do_start(3, 2'b00, '0, 1'b0);
    n_tests++;
    if (out_data[31:0] !== 32'h6018_0001) begin
      n_fail++;
      $display("FAIL reseed_continue got %h, expected 60180001", out_data[31:0]);
    end
    drain();
    reseed = 1'b1;
    drive('0);
    reseed = 1'b0;
    model_reseed();
    do_start(3, 2'b00, '0, 1'b0);
    n_tests++;
    if (out_data[31:0] !== 32'h0000_0001 || out_data[DW +: DW] !== exp_data(1)) begin
      n_fail++;
      $display("FAIL reseed_idle got ch0=%h ch1=%h, expected 00000001 %h", out_data[31:0], out_data[DW +: DW], exp_data(1));
    end
    drain();
    do_start(2, 2'b00, '0, 1'b1);
    n_tests++;
    if (out_data[31:0] !== 32'h0000_0001) begin
      n_fail++;
      $display("FAIL reseed_with_start got %h, expected 00000001", out_data[31:0]);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NCH-1:0] ev;
    int done_cyc = -1;
    do_start(4, 2'b01, '0, 1'b0);
    for (int cyc = 0; cyc < 40 && (m_busy || m_done); cyc++) begin
      ev = exp_valid();
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      n_tests++;
      if (busy !== m_busy || done !== m_done || out_valid !== ev) begin
        n_fail++;
        $display("FAIL bp_ctrl cyc=%0d got busy=%b done=%b valid=%b, expected %b %b %b",
                 cyc, busy, done, out_valid, m_busy, m_done, ev);
      end
      for (int c = 0; c < NCH; c++) if (ev[c] || !m_busy) begin
        n_tests++;
        if (out_data[c*DW +: DW] !== exp_data(c)) begin
          n_fail++;
          $display("FAIL bp_data cyc=%0d ch%0d got %h, expected %h", cyc, c, out_data[c*DW +: DW], exp_data(c));
        end
      end
      drive((cyc < 5) ? 2'b01 : 2'b11);
    end
    n_tests++;
    if (done_cyc != 9) begin
      n_fail++;
      $display("FAIL bp_done_cycle got %0d, expected 9", done_cyc);
    end
  endtask

  task automatic test_modes();
    logic [NCH-1:0] ev;
    logic [1:0] mds [2];
    int lens [2];
    mds[0] = 2'b11; lens[0] = 42;
    mds[1] = 2'b10; lens[1] = 2;
    for (int t = 0; t < 2; t++) begin
      do_start(lens[t], mds[t], DW'(40'hA5_5A3C_C3A5), 1'b0);
      for (int cyc = 0; cyc < 200 && (m_busy || m_done); cyc++) begin
        ev = exp_valid();
        n_tests++;
        if (busy !== m_busy || done !== m_done || out_valid !== ev) begin
          n_fail++;
          $display("FAIL modes_ctrl m=%0d cyc=%0d got busy=%b done=%b valid=%b, expected %b %b %b",
                   mds[t], cyc, busy, done, out_valid, m_busy, m_done, ev);
        end
        for (int c = 0; c < NCH; c++) if (ev[c] || !m_busy) begin
          n_tests++;
          if (out_data[c*DW +: DW] !== exp_data(c)) begin
            n_fail++;
            $display("FAIL modes_data m=%0d cyc=%0d ch%0d got %h, expected %h",
                     mds[t], cyc, c, out_data[c*DW +: DW], exp_data(c));
          end
        end
        drive(2'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic test_zero_len();
    do_start(0, 2'b01, '0, 1'b0);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== '0) begin
      n_fail++;
      $display("FAIL zero_len_done got done=%b busy=%b valid=%b, expected 1 0 00", done, busy, out_valid);
    end
    drive('1);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (done !== 1'b0 || out_valid !== '0) begin
        n_fail++;
        $display("FAIL zero_len_after got done=%b valid=%b, expected 0 00", done, out_valid);
      end
      drive('1);
    end
  endtask

  task automatic test_start_ignored();
    logic [NCH-1:0] ev;
    int acc0 = 0;
    do_start(5, 2'b01, '0, 1'b0);
    for (int cyc = 0; cyc < 60 && (m_busy || m_done); cyc++) begin
      ev = exp_valid();
      start     = (cyc == 1) || (cyc == 3) || m_done;
      burst_len = LW'(20);
      mode      = 2'b11;
      n_tests++;
      if (out_valid !== ev || (ev[0] && out_data[DW-1:0] !== exp_data(0))) begin
        n_fail++;
        $display("FAIL start_ign cyc=%0d got valid=%b ch0=%h, expected %b %h", cyc, out_valid, out_data[DW-1:0], ev, exp_data(0));
      end
      out_ready = 2'($urandom_range(1, 3)) | 2'b01;
      if (ev[0] && out_ready[0]) acc0++;
      drive(out_ready);
    end
    start = 1'b0;
    n_tests++;
    if (acc0 != 5 || busy !== 1'b0 || out_valid !== '0) begin
      n_fail++;
      $display("FAIL start_ign_count got accepts=%0d busy=%b valid=%b, expected 5 0 00", acc0, busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_start(5, 2'b00, '0, 1'b1);
    drive(2'b11);
    drive(2'b11);
    rst = 1'b0;
    out_ready = '1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== '0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b done=%b valid=%b data=%h, expected zeros", busy, done, out_valid, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_nodone cyc=%0d got done=%b busy=%b, expected 0 0", i, done, busy);
      end
      drive('1);
    end
    do_start(5, 2'b00, '0, 1'b0);
    n_tests++;
    if (out_data[31:0] !== 32'h0000_0001 || out_data[DW +: DW] !== exp_data(1)) begin
      n_fail++;
      $display("FAIL reset_mid_seed got ch0=%h ch1=%h, expected 00000001 %h", out_data[31:0], out_data[DW +: DW], exp_data(1));
    end
    drain();
  endtask

  task automatic test_random_bursts();
    logic [NCH-1:0] ev;
    logic [NCH-1:0] rdy;
    int len;
    int pct;
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(0, 24));
      pct = int'($urandom_range(25, 100));
      do_start(len, 2'($urandom_range(0, 3)), DW'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
      for (int cyc = 0; cyc < 400 && (m_busy || m_done); cyc++) begin
        ev = exp_valid();
        n_tests++;
        if (busy !== m_busy || done !== m_done || out_valid !== ev) begin
          n_fail++;
          $display("FAIL rand_ctrl it=%0d cyc=%0d got busy=%b done=%b valid=%b, expected %b %b %b",
                   it, cyc, busy, done, out_valid, m_busy, m_done, ev);
        end
        for (int c = 0; c < NCH; c++) if (ev[c] || !m_busy) begin
          n_tests++;
          if (out_data[c*DW +: DW] !== exp_data(c)) begin
            n_fail++;
            $display("FAIL rand_data it=%0d cyc=%0d ch%0d got %h, expected %h",
                     it, cyc, c, out_data[c*DW +: DW], exp_data(c));
          end
        end
        for (int c = 0; c < NCH; c++) rdy[c] = ($urandom_range(0, 99) < pct);
        drive(rdy);
      end
      n_tests++;
      if (m_busy || m_done || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_timeout it=%0d got busy=%b, expected burst finished", it, busy);
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    reseed    = 1'b0;
    burst_len = '0;
    mode      = 2'b00;
    cfg_const = '0;
    out_ready = '0;
    model_reset();
    test_reset();
    test_lfsr();
    test_reseed();
    test_backpressure();
    test_modes();
    test_zero_len();
    test_start_ignored();
    test_reset_mid();
    test_random_bursts();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
